// File: rtl/product_accumulator_pkg.sv
// Shared definitions for the product accumulator: product width and FSM state encoding.
// The product width matches the P output of the upstream Multi16 multiplier.
package product_accumulator_pkg;

   localparam int MULT_P_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_FULL  = 2'd2
   } acc_state_t;

endpackage

// File: rtl/product_accumulator_acc_add_ovf.sv
// Combinational ACC_W+1-bit adder: accumulator plus a zero-extended product,
// returning the ACC_W-bit sum and the carry out of the top bit.
module acc_add_ovf #(
   parameter int DATA_W = 32,
   parameter int ACC_W  = 40
) (
   input  logic [ACC_W-1:0]  acc_in,
   input  logic [DATA_W-1:0] data_in,
   output logic [ACC_W-1:0]  sum,
   output logic              carry
);

   logic [ACC_W:0] wide;

   assign wide  = {1'b0, acc_in} + (ACC_W+1)'(data_in);
   assign sum   = wide[ACC_W-1:0];
   assign carry = wide[ACC_W];

endmodule

// File: rtl/product_accumulator.sv
// Sums LEN consecutive unsigned products into an ACC_W-bit block sum with a sticky
// overflow flag, and holds each finished block on a buffered valid/ready output.
module product_accumulator
   import product_accumulator_pkg::*;
#(
   parameter int DATA_W = MULT_P_W,
   parameter int ACC_W  = 40,
   parameter int LEN    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic              out_ovf,
   output logic              busy
);

   localparam int CNT_W = $clog2(LEN + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

   acc_state_t       state;
   logic [ACC_W-1:0] acc;
   logic             ovf;
   logic [CNT_W-1:0] cnt;

   logic             accept;
   logic             last_beat;
   logic             drain;
   logic [ACC_W-1:0] add_base;
   logic [ACC_W-1:0] add_sum;
   logic             add_carry;
   logic             ovf_next;

   // A pending result only stalls upstream while the consumer is not taking it.
   assign in_ready  = !clr && ((state != ST_FULL) || out_ready);
   assign accept    = in_valid && in_ready;
   assign last_beat = (cnt == LAST);
   assign drain     = (state == ST_FULL) && out_ready && !clr;

   // The first beat of a block starts from zero regardless of stale acc/ovf contents.
   assign add_base  = (cnt == '0) ? '0 : acc;
   assign ovf_next  = ((cnt != '0) && ovf) || add_carry;
   assign busy      = (cnt != '0);

   acc_add_ovf #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_add (
      .acc_in  (add_base),
      .data_in (in_data),
      .sum     (add_sum),
      .carry   (add_carry)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         acc       <= '0;
         ovf       <= 1'b0;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_ovf   <= 1'b0;
      end else if (clr) begin
         acc <= '0;
         ovf <= 1'b0;
         cnt <= '0;
         if (state != ST_FULL) begin
            state <= ST_IDLE;
         end
      end else if (accept && last_beat) begin
         // Completing a block overwrites any result being drained this same cycle.
         out_sum   <= add_sum;
         out_ovf   <= ovf_next;
         out_valid <= 1'b1;
         acc       <= '0;
         ovf       <= 1'b0;
         cnt       <= '0;
         state     <= ST_FULL;
      end else begin
         if (accept) begin
            acc <= add_sum;
            ovf <= ovf_next;
            cnt <= cnt + 1'b1;
         end
         if (drain) begin
            out_valid <= 1'b0;
            state     <= (accept || (cnt != '0)) ? ST_ACCUM : ST_IDLE;
         end else if (accept) begin
            state <= ST_ACCUM;
         end
      end
   end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: default, ACC_W=33 and LEN=1 instances,
// a table of nominal blocks plus hand-written multi-cycle sequences.
module tb_product_accumulator;

   logic clk = 1'b0;
   logic rst;

   logic        a_clr, a_valid, a_ready, a_out_valid, a_out_ready, a_ovf, a_busy;
   logic [31:0] a_data;
   logic [39:0] a_sum;

   logic        b_clr, b_valid, b_ready, b_out_valid, b_out_ready, b_ovf, b_busy;
   logic [31:0] b_data;
   logic [32:0] b_sum;

   logic        c_clr, c_valid, c_ready, c_out_valid, c_out_ready, c_ovf, c_busy;
   logic [31:0] c_data;
   logic [39:0] c_sum;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [3:0][31:0] d;
      logic [39:0]      exp_sum;
      logic             exp_ovf;
   } vec_t;

   vec_t vecs[5];

   always #5 clk = ~clk;

   product_accumulator dut_a (
      .clk(clk), .rst(rst), .clr(a_clr), .in_valid(a_valid), .in_ready(a_ready),
      .in_data(a_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_sum(a_sum), .out_ovf(a_ovf), .busy(a_busy)
   );

   product_accumulator #(.ACC_W(33)) dut_b (
      .clk(clk), .rst(rst), .clr(b_clr), .in_valid(b_valid), .in_ready(b_ready),
      .in_data(b_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_sum(b_sum), .out_ovf(b_ovf), .busy(b_busy)
   );

   product_accumulator #(.LEN(1)) dut_c (
      .clk(clk), .rst(rst), .clr(c_clr), .in_valid(c_valid), .in_ready(c_ready),
      .in_data(c_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
      .out_sum(c_sum), .out_ovf(c_ovf), .busy(c_busy)
   );

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic setIn(input int u, input logic v, input logic [31:0] d);
      case (u)
         0: begin a_valid = v; a_data = d; end
         1: begin b_valid = v; b_data = d; end
         default: begin c_valid = v; c_data = d; end
      endcase
   endtask

   function automatic logic readyOf(input int u);
      case (u)
         0: return a_ready;
         1: return b_ready;
         default: return c_ready;
      endcase
   endfunction

   // Must be called just after a rising edge; returns just after the accepting edge.
   task automatic applyStimulus(input int u, input logic [31:0] d);
      int n;
      n = 0;
      setIn(u, 1'b1, d);
      @(negedge clk);
      while (!readyOf(u) && n < 20) begin
         n++;
         @(negedge clk);
      end
      if (!readyOf(u)) begin
         checks++;
         errors++;
         $display("[TB] FAIL beat_timeout: in_ready got 0, expected 1 on unit %0d", u);
      end
      @(posedge clk);
      #1;
      setIn(u, 1'b0, 32'd0);
   endtask

   task automatic sendBlock(input int u, input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] d3);
      applyStimulus(u, d0);
      applyStimulus(u, d1);
      applyStimulus(u, d2);
      applyStimulus(u, d3);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vecs[0] = '{d: {32'd0, 32'd100, 32'd15, 32'd14884}, exp_sum: 40'd14999, exp_ovf: 1'b0};
      vecs[1] = '{d: {32'd5, 32'd5, 32'd5, 32'd5}, exp_sum: 40'd20, exp_ovf: 1'b0};
      vecs[2] = '{d: {32'd400, 32'd300, 32'd200, 32'd100}, exp_sum: 40'd1000, exp_ovf: 1'b0};
      vecs[3] = '{d: {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
                  exp_sum: 40'h3_FFFF_FFFC, exp_ovf: 1'b0};
      vecs[4] = '{d: {32'd0, 32'd0, 32'd0, 32'd0}, exp_sum: 40'd0, exp_ovf: 1'b0};

      a_clr = 0; a_valid = 0; a_data = 0; a_out_ready = 1;
      b_clr = 0; b_valid = 0; b_data = 0; b_out_ready = 1;
      c_clr = 0; c_valid = 0; c_data = 0; c_out_ready = 1;
      rst = 1'b1;

      repeat (2) @(negedge clk);
      checkOutput("rst_out_valid", a_out_valid, 0);
      checkOutput("rst_out_sum", a_sum, 0);
      checkOutput("rst_out_ovf", a_ovf, 0);
      checkOutput("rst_busy", a_busy, 0);
      step();
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_in_ready_a", a_ready, 1);
      checkOutput("rst_in_ready_b", b_ready, 1);
      checkOutput("rst_in_ready_c", c_ready, 1);

      // Nominal blocks, consumer always ready
      for (int i = 0; i < 5; i++) begin
         step();
         checkOutput($sformatf("vec%0d_pre_valid", i), a_out_valid, 0);
         sendBlock(0, vecs[i].d[0], vecs[i].d[1], vecs[i].d[2], vecs[i].d[3]);
         @(negedge clk);
         checkOutput($sformatf("vec%0d_valid", i), a_out_valid, 1);
         checkOutput($sformatf("vec%0d_sum", i), a_sum, vecs[i].exp_sum);
         checkOutput($sformatf("vec%0d_ovf", i), a_ovf, vecs[i].exp_ovf);
         @(negedge clk);
         checkOutput($sformatf("vec%0d_drained", i), a_out_valid, 0);
      end

      // Reset in the middle of a block
      step();
      applyStimulus(0, 32'd11);
      applyStimulus(0, 32'd22);
      @(negedge clk);
      checkOutput("midrst_busy_before", a_busy, 1);
      rst = 1'b1;
      #1;
      checkOutput("midrst_busy_async", a_busy, 0);
      step();
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midrst_out_valid", a_out_valid, 0);
      checkOutput("midrst_busy", a_busy, 0);
      checkOutput("midrst_in_ready", a_ready, 1);
      step();
      sendBlock(0, 32'd1, 32'd1, 32'd1, 32'd1);
      @(negedge clk);
      checkOutput("midrst_sum", a_sum, 4);
      checkOutput("midrst_valid", a_out_valid, 1);
      @(negedge clk);

      // Backpressure: result held, upstream stalled, pending beat not lost
      step();
      a_out_ready = 1'b0;
      sendBlock(0, 32'd1, 32'd2, 32'd3, 32'd4);
      @(negedge clk);
      checkOutput("bp_valid", a_out_valid, 1);
      checkOutput("bp_sum", a_sum, 10);
      setIn(0, 1'b1, 32'd5);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("bp_in_ready_low", a_ready, 0);
         checkOutput("bp_sum_stable", a_sum, 10);
         checkOutput("bp_valid_stable", a_out_valid, 1);
      end
      a_out_ready = 1'b1;
      step();
      setIn(0, 1'b0, 32'd0);
      @(negedge clk);
      checkOutput("bp_release_valid", a_out_valid, 0);
      checkOutput("bp_release_busy", a_busy, 1);
      step();
      applyStimulus(0, 32'd5);
      applyStimulus(0, 32'd5);
      applyStimulus(0, 32'd5);
      @(negedge clk);
      checkOutput("bp_next_valid", a_out_valid, 1);
      checkOutput("bp_next_sum", a_sum, 20);
      @(negedge clk);

      // clr mid-block with a beat presented in the same cycle
      step();
      applyStimulus(0, 32'd7);
      applyStimulus(0, 32'd9);
      a_clr = 1'b1;
      setIn(0, 1'b1, 32'd50);
      @(negedge clk);
      checkOutput("clr_in_ready", a_ready, 0);
      step();
      a_clr = 1'b0;
      setIn(0, 1'b0, 32'd0);
      @(negedge clk);
      checkOutput("clr_busy", a_busy, 0);
      checkOutput("clr_no_valid", a_out_valid, 0);
      step();
      sendBlock(0, 32'd1, 32'd2, 32'd3, 32'd4);
      @(negedge clk);
      checkOutput("clr_sum", a_sum, 10);
      checkOutput("clr_valid", a_out_valid, 1);
      @(negedge clk);

      // clr while a result is pending keeps the result, even with out_ready high
      step();
      a_out_ready = 1'b0;
      sendBlock(0, 32'd1, 32'd1, 32'd1, 32'd1);
      a_clr = 1'b1;
      a_out_ready = 1'b1;
      step();
      a_clr = 1'b0;
      @(negedge clk);
      checkOutput("clrfull_valid", a_out_valid, 1);
      checkOutput("clrfull_sum", a_sum, 4);
      @(negedge clk);
      checkOutput("clrfull_drained", a_out_valid, 0);

      // Overflow with ACC_W=33
      step();
      sendBlock(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
      @(negedge clk);
      checkOutput("ovf_valid", b_out_valid, 1);
      checkOutput("ovf_sum", b_sum, 33'h1_FFFF_FFFC);
      checkOutput("ovf_flag", b_ovf, 1);
      @(negedge clk);
      step();
      sendBlock(1, 32'd1, 32'd1, 32'd1, 32'd1);
      @(negedge clk);
      checkOutput("ovf_next_sum", b_sum, 4);
      checkOutput("ovf_next_flag", b_ovf, 0);

      // LEN=1: drain and accept in the same cycle, back-to-back
      step();
      setIn(2, 1'b1, 32'd3);
      @(negedge clk);
      checkOutput("len1_ready", c_ready, 1);
      step();
      setIn(2, 1'b1, 32'd6);
      @(negedge clk);
      checkOutput("len1_valid_first", c_out_valid, 1);
      checkOutput("len1_sum_first", c_sum, 3);
      checkOutput("len1_ready_full", c_ready, 1);
      step();
      setIn(2, 1'b0, 32'd0);
      @(negedge clk);
      checkOutput("len1_valid_second", c_out_valid, 1);
      checkOutput("len1_sum_second", c_sum, 6);
      @(negedge clk);
      checkOutput("len1_drained", c_out_valid, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
